// File: rtl/vjtag_reg_ctrl.sv
// Virtual-JTAG to register-bus bridge: shifts address/data frames through a DR
// chain and turns each update into a single register write or read access.
module vjtag_reg_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_TIMEOUT = 15
) (
  input  logic              tck,
  input  logic              rst_n,
  input  logic              tdi,
  output logic              tdo,
  input  logic              ir_in,
  output logic              ir_out,
  input  logic              virtual_state_cdr,
  input  logic              virtual_state_sdr,
  input  logic              virtual_state_e1dr,
  input  logic              virtual_state_pdr,
  input  logic              virtual_state_e2dr,
  input  logic              virtual_state_udr,
  input  logic              virtual_state_cir,
  input  logic              virtual_state_uir,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_rvalid,
  output logic              busy
);
  localparam int FW = ADDR_W + DATA_W;
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [5:0]    FW_CNT   = 6'(FW);
  localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, WRITE = 2'd2, RD_WAIT = 2'd3} state_t;

  state_t            state, state_next;
  logic              mode;
  logic              err_sticky;
  logic [FW-1:0]     sr;
  logic [5:0]        bit_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] rd_buf;
  logic [TW-1:0]     tmo_cnt;
  logic do_cap, do_shift, do_wr, do_rd, rd_done, rd_tmo, set_err;

  // Pause/exit states only hold, and cir is deliberately inert.
  logic unused_inputs;
  assign unused_inputs = ^{virtual_state_e1dr, virtual_state_pdr,
                           virtual_state_e2dr, virtual_state_cir};

  // Next state and per-cycle actions; udr outranks cdr, which outranks sdr.
  always_comb begin
    state_next = state;
    do_cap     = 1'b0;
    do_shift   = 1'b0;
    do_wr      = 1'b0;
    do_rd      = 1'b0;
    rd_done    = 1'b0;
    rd_tmo     = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (!virtual_state_udr && virtual_state_cdr) begin
          do_cap     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (virtual_state_udr) begin
          if (bit_cnt != FW_CNT) begin
            set_err    = 1'b1;
            state_next = IDLE;
          end else if (mode) begin
            do_wr      = 1'b1;
            state_next = WRITE;
          end else begin
            do_rd      = 1'b1;
            state_next = RD_WAIT;
          end
        end else if (virtual_state_cdr) begin
          do_cap = 1'b1;
        end else if (virtual_state_sdr) begin
          do_shift = 1'b1;
        end else begin
          state_next = SHIFT;
        end
      end
      WRITE: begin
        set_err    = virtual_state_cdr & ~virtual_state_udr;
        state_next = IDLE;
      end
      RD_WAIT: begin
        set_err = virtual_state_cdr & ~virtual_state_udr;
        if (reg_rvalid) begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          rd_tmo     = 1'b1;
          set_err    = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = RD_WAIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and datapath.
  always_ff @(posedge tck) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode       <= 1'b0;
      err_sticky <= 1'b0;
      sr         <= '0;
      bit_cnt    <= 6'd0;
      last_addr  <= '0;
      rd_buf     <= '0;
      tmo_cnt    <= '0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
    end else begin
      state  <= state_next;
      reg_we <= do_wr;
      reg_re <= do_rd;
      if (virtual_state_uir) mode <= ir_in;
      if (set_err) err_sticky <= 1'b1;
      else if (virtual_state_uir) err_sticky <= 1'b0;
      if (do_cap) begin
        sr      <= {last_addr, rd_buf};
        bit_cnt <= 6'd0;
      end else if (do_shift) begin
        sr <= {tdi, sr[FW-1:1]};
        if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
      end
      if (do_wr || do_rd) begin
        reg_addr  <= sr[FW-1:DATA_W];
        last_addr <= sr[FW-1:DATA_W];
      end
      if (do_wr) reg_wdata <= sr[DATA_W-1:0];
      if (do_rd) tmo_cnt <= '0;
      else if (state == RD_WAIT) tmo_cnt <= tmo_cnt + TW'(1);
      if (rd_done) rd_buf <= reg_rdata;
      else if (rd_tmo) rd_buf <= '1;
    end
  end

  assign tdo    = (state == SHIFT) ? sr[0] : 1'b0;
  assign busy   = (state == WRITE) || (state == RD_WAIT);
  assign ir_out = err_sticky;
endmodule
